// File: rtl/mips_cpu_mem_pkg.sv
// Shared types and helpers for the load/store bus sequencer and the downstream wordmask stage.
package mips_cpu_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned MSK_W  = 3;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LW  = 4'd0,
    OP_LH  = 4'd1,
    OP_LHU = 4'd2,
    OP_LB  = 4'd3,
    OP_LBU = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SW  = 4'd7,
    OP_SH  = 4'd8,
    OP_SB  = 4'd9
  } mem_op_t;

  // Mode codes understood by wordmask.
  localparam logic [MSK_W-1:0] MSK_WORD  = 3'b000;
  localparam logic [MSK_W-1:0] MSK_HALF  = 3'b001;
  localparam logic [MSK_W-1:0] MSK_HALFU = 3'b010;
  localparam logic [MSK_W-1:0] MSK_BYTE  = 3'b011;
  localparam logic [MSK_W-1:0] MSK_BYTEU = 3'b100;
  localparam logic [MSK_W-1:0] MSK_LWL   = 3'b101;
  localparam logic [MSK_W-1:0] MSK_LWR   = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } mem_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Only the low address bits matter for alignment.
  function automatic logic is_misaligned(input mem_op_t op, input logic [OFF_W-1:0] addr);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad = (addr != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = addr[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [MSK_W-1:0] msk_code(input mem_op_t op);
    logic [MSK_W-1:0] code;
    code = MSK_WORD;
    case (op)
      OP_LH:   code = MSK_HALF;
      OP_LHU:  code = MSK_HALFU;
      OP_LB:   code = MSK_BYTE;
      OP_LBU:  code = MSK_BYTEU;
      OP_LWL:  code = MSK_LWL;
      OP_LWR:  code = MSK_LWR;
      default: code = MSK_WORD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mips_cpu_store_align.sv
// Combinational byte-lane and store-data alignment for a single 32-bit little-endian access.
module mips_cpu_store_align
  import mips_cpu_mem_pkg::*;
(
  input  mem_op_t                 op,
  input  logic [OFF_W-1:0]        addr_lo,
  input  logic [DATA_W-1:0]       wdata,
  output logic [BE_W-1:0]         byteenable_c,
  output logic [DATA_W-1:0]       writedata_c
);

  // Loads read the full word; wordmask does the lane extraction.
  always_comb begin
    byteenable_c = 4'b1111;
    writedata_c  = '0;
    case (op)
      OP_SW: begin
        writedata_c = wdata;
      end
      OP_SH: begin
        byteenable_c = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata_c  = {2{wdata[15:0]}};
      end
      OP_SB: begin
        byteenable_c = BE_W'(4'b0001 << addr_lo);
        writedata_c  = {4{wdata[7:0]}};
      end
      default: begin
        byteenable_c = 4'b1111;
        writedata_c  = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_access.sv
// Load/store sequencer: one Avalon-MM access per request, raw read word plus wordmask codes back.
module mips_cpu_mem_access
  import mips_cpu_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  mem_op_t              req_op,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [BE_W-1:0]      avm_byteenable,
  output logic [DATA_W-1:0]    avm_writedata,
  input  logic [DATA_W-1:0]    avm_readdata,
  input  logic                 avm_waitrequest,
  output logic                 resp_valid,
  output logic [DATA_W-1:0]    resp_data,
  output logic [MSK_W-1:0]     resp_msk_cnt,
  output logic [OFF_W-1:0]     resp_msk_cnt2,
  output logic                 resp_err
);

  mem_state_t          state;
  logic [BE_W-1:0]     be_c;
  logic [DATA_W-1:0]   wd_c;
  logic                misaligned_c;
  logic                store_c;

  assign misaligned_c = is_misaligned(req_op, req_addr[OFF_W-1:0]);
  assign store_c      = is_store(req_op);

  mips_cpu_store_align u_store_align (
    .op           (req_op),
    .addr_lo      (req_addr[OFF_W-1:0]),
    .wdata        (req_wdata),
    .byteenable_c (be_c),
    .writedata_c  (wd_c)
  );

  // Bus address, lanes and data are captured at accept so they stay stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_msk_cnt   <= '0;
      resp_msk_cnt2  <= '0;
      resp_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready     <= 1'b0;
            resp_data     <= '0;
            resp_msk_cnt  <= msk_code(req_op);
            resp_msk_cnt2 <= req_addr[OFF_W-1:0];
            resp_err      <= misaligned_c;
            if (misaligned_c) begin
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              avm_address    <= {req_addr[ADDR_W-1:OFF_W], 2'b00};
              avm_byteenable <= be_c;
              avm_writedata  <= wd_c;
              if (store_c) begin
                avm_write <= 1'b1;
                state     <= ST_WRITE;
              end else begin
                avm_read <= 1'b1;
                state    <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (!avm_waitrequest) begin
            avm_read   <= 1'b0;
            resp_data  <= avm_readdata;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          if (!avm_waitrequest) begin
            avm_write  <= 1'b0;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          avm_read   <= 1'b0;
          avm_write  <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_access.sv
// Self-checking bench: directed vector table, random transactions against a behavioural model, reset and throughput sequences.
module tb_mips_cpu_mem_access;
  import mips_cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [2:0]  resp_msk_cnt;
  logic [1:0]  resp_msk_cnt2;
  logic        resp_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mips_cpu_mem_access dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_msk_cnt    (resp_msk_cnt),
    .resp_msk_cnt2   (resp_msk_cnt2),
    .resp_err        (resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        err;
    logic        store;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [2:0]  msk;
  } exp_t;

  // Reference: derive expected bus/response fields from access size and byte offset.
  function automatic exp_t model(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t m;
    int off;
    int size;
    off     = int'(addr % 32'd4);
    m.store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    m.be    = 4'hF;
    m.wd    = 32'd0;
    case (op)
      OP_LH:   m.msk = 3'd1;
      OP_LHU:  m.msk = 3'd2;
      OP_LB:   m.msk = 3'd3;
      OP_LBU:  m.msk = 3'd4;
      OP_LWL:  m.msk = 3'd5;
      OP_LWR:  m.msk = 3'd6;
      default: m.msk = 3'd0;
    endcase
    case (op)
      OP_LW, OP_SW:         size = 4;
      OP_LH, OP_LHU, OP_SH: size = 2;
      default:              size = 1;
    endcase
    m.err = (off % size) != 0;
    if (op == OP_SW) m.wd = wdata;
    if (op == OP_SH) begin
      m.wd = (wdata & 32'h0000FFFF) * 32'h00010001;
      m.be = (off >= 2) ? 4'hC : 4'h3;
    end
    if (op == OP_SB) begin
      m.wd = (wdata & 32'h000000FF) * 32'h01010101;
      m.be = 4'(1 << off);
    end
    return m;
  endfunction

  // One complete request: accept, bus phase with nwait stalls, response pulse, return to idle.
  task automatic run_txn(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int nwait, input logic err, input logic store,
                         input logic [3:0] be, input logic [31:0] wd, input logic [2:0] msk);
    logic [31:0] exp_data;
    int guard;
    exp_data = (err || store) ? 32'd0 : rdata;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid       = 1'b1;
    req_op          = op;
    req_addr        = addr;
    req_wdata       = wdata;
    avm_waitrequest = 1'b1;
    avm_readdata    = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (err) begin
      chk("err_no_read", 32'(avm_read), 32'd0);
      chk("err_no_write", 32'(avm_write), 32'd0);
    end else begin
      for (int c = 1; c <= nwait + 1; c++) begin
        if (c > 1) @(negedge clk);
        chk("strobe_read", 32'(avm_read), 32'(!store));
        chk("strobe_write", 32'(avm_write), 32'(store));
        chk("avm_address", avm_address, addr & 32'hFFFF_FFFC);
        chk("avm_byteenable", 32'(avm_byteenable), 32'(be));
        if (store) chk("avm_writedata", avm_writedata, wd);
        chk("busy_not_ready", 32'(req_ready), 32'd0);
        chk("no_early_resp", 32'(resp_valid), 32'd0);
        avm_waitrequest = (c <= nwait);
        avm_readdata    = (c <= nwait) ? $urandom : rdata;
      end
      @(negedge clk);
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("resp_data", resp_data, exp_data);
    chk("resp_msk_cnt", 32'(resp_msk_cnt), 32'(msk));
    chk("resp_msk_cnt2", 32'(resp_msk_cnt2), addr % 32'd4);
    chk("resp_no_strobe", 32'({avm_read, avm_write}), 32'd0);
    chk("resp_not_ready", 32'(req_ready), 32'd0);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
    chk("resp_data_hold", resp_data, exp_data);
    chk("resp_msk_hold", 32'(resp_msk_cnt), 32'(msk));
  endtask

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          nwait;
    logic        err;
    logic        store;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [2:0]  msk;
  } vec_t;

  vec_t vecs[$];

  initial begin
    exp_t m;
    mem_op_t rop;
    logic [31:0] ra, rw, rr;
    int rn;

    vecs.push_back(vec_t'{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 1'b0, 4'hF, 32'h0,        3'd0});
    vecs.push_back(vec_t'{OP_LB,  32'h203, 32'h0,        32'h11223344, 3, 1'b0, 1'b0, 4'hF, 32'h0,        3'd3});
    vecs.push_back(vec_t'{OP_SB,  32'h301, 32'h000000A5, 32'h0,        0, 1'b0, 1'b1, 4'h2, 32'hA5A5A5A5, 3'd0});
    vecs.push_back(vec_t'{OP_SH,  32'h402, 32'h00001234, 32'h0,        1, 1'b0, 1'b1, 4'hC, 32'h12341234, 3'd0});
    vecs.push_back(vec_t'{OP_LW,  32'h102, 32'h0,        32'h55555555, 0, 1'b1, 1'b0, 4'hF, 32'h0,        3'd0});
    vecs.push_back(vec_t'{OP_LWR, 32'h102, 32'h0,        32'hCAFEF00D, 0, 1'b0, 1'b0, 4'hF, 32'h0,        3'd6});
    vecs.push_back(vec_t'{OP_SW,  32'h7FC, 32'h89ABCDEF, 32'h0,        2, 1'b0, 1'b1, 4'hF, 32'h89ABCDEF, 3'd0});
    vecs.push_back(vec_t'{OP_SH,  32'h401, 32'h0000BEEF, 32'h0,        0, 1'b1, 1'b1, 4'hF, 32'h0,        3'd0});
    vecs.push_back(vec_t'{OP_LHU, 32'h806, 32'h0,        32'h0BADC0DE, 0, 1'b0, 1'b0, 4'hF, 32'h0,        3'd2});
    vecs.push_back(vec_t'{OP_LH,  32'h805, 32'h0,        32'h12345678, 0, 1'b1, 1'b0, 4'hF, 32'h0,        3'd1});
    vecs.push_back(vec_t'{OP_LWL, 32'h903, 32'h0,        32'hA1B2C3D4, 1, 1'b0, 1'b0, 4'hF, 32'h0,        3'd5});
    vecs.push_back(vec_t'{OP_LBU, 32'hA02, 32'h0,        32'hFEDCBA98, 0, 1'b0, 1'b0, 4'hF, 32'h0,        3'd4});
    vecs.push_back(vec_t'{OP_SB,  32'hB03, 32'h0000005A, 32'h0,        0, 1'b0, 1'b1, 4'h8, 32'h5A5A5A5A, 3'd0});
    vecs.push_back(vec_t'{OP_SH,  32'hC00, 32'hFFFFBEEF, 32'h0,        0, 1'b0, 1'b1, 4'h3, 32'hBEEFBEEF, 3'd0});
    vecs.push_back(vec_t'{OP_SW,  32'hD02, 32'h11111111, 32'h0,        0, 1'b1, 1'b1, 4'hF, 32'h0,        3'd0});

    reset           = 1'b1;
    req_valid       = 1'b0;
    req_op          = OP_LW;
    req_addr        = 32'd0;
    req_wdata       = 32'd0;
    avm_readdata    = 32'd0;
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_avm_address", avm_address, 32'd0);
    chk("rst_avm_byteenable", 32'(avm_byteenable), 32'd0);
    chk("rst_avm_writedata", avm_writedata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_msk", 32'({resp_msk_cnt, resp_msk_cnt2, resp_err}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i])
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].nwait,
              vecs[i].err, vecs[i].store, vecs[i].be, vecs[i].wd, vecs[i].msk);

    // Back-to-back with req_valid held: second accept only after RESP, three cycles per access.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h3; req_wdata = 32'h77; avm_waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_write1", 32'(avm_write), 32'd1);
    chk("b2b_be1", 32'(avm_byteenable), 32'h8);
    @(negedge clk);
    chk("b2b_resp1", 32'(resp_valid), 32'd1);
    chk("b2b_resp_not_ready", 32'(req_ready), 32'd0);
    chk("b2b_resp_no_strobe", 32'(avm_write), 32'd0);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    chk("b2b_idle_no_strobe", 32'(avm_write), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_write2", 32'(avm_write), 32'd1);
    @(negedge clk);
    chk("b2b_resp2", 32'(resp_valid), 32'd1);
    @(negedge clk);
    chk("b2b_ready2", 32'(req_ready), 32'd1);

    // Reset while a read is stalled.
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h500; avm_waitrequest = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_read_active", 32'(avm_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_read_drop", 32'(avm_read), 32'd0);
    chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
      chk("post_rst_no_read", 32'(avm_read), 32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
    end

    for (int t = 0; t < 200; t++) begin
      rop = mem_op_t'(4'($urandom_range(0, 9)));
      ra  = $urandom;
      rw  = $urandom;
      rr  = $urandom;
      rn  = $urandom_range(0, 3);
      m   = model(rop, ra, rw);
      run_txn(rop, ra, rw, rr, rn, m.err, m.store, m.be, m.wd, m.msk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_cpu_mem_access.md
# mips_cpu_mem_access

Load/store bus sequencer sitting directly upstream of the `wordmask` stage. It accepts one memory request at a time from the execute stage and runs a single Avalon-MM read or write on a word-aligned address, with byte lanes and store data aligned. For loads it returns the raw 32-bit read word together with the `msk_cnt`/`msk_cnt2` codes that `wordmask` consumes. It also stalls the core while the bus asserts `waitrequest`.

## Interface
Parameters:
- none. The bus is fixed at 32-bit data and 32-bit byte address.

Ports:
- `clk` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 4: `mem_op_t` (LW, LH, LHU, LB, LBU, LWL, LWR, SW, SH, SB).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, with the value in the low bits.
- `avm_address` out 32: `{req_addr[31:2],2'b00}`.
- `avm_read`, `avm_write` out 1 each: bus strobes.
- `avm_byteenable` out 4: active byte lanes.
- `avm_writedata` out 32: lane-aligned store data.
- `avm_readdata` in 32: read data.
- `avm_waitrequest` in 1: slave stall.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 32: latched read word; 0 for stores and errors.
- `resp_msk_cnt` out 3: `wordmask` mode code.
- `resp_msk_cnt2` out 2: `req_addr[1:0]` latched at accept.
- `resp_err` out 1: misaligned access; no bus cycle was issued.

## Operation
Mask code (`resp_msk_cnt`), by op:
- LW, SW, SH, SB: 000
- LH: 001
- LHU: 010
- LB: 011
- LBU: 100
- LWL: 101
- LWR: 110

Alignment rules:
- LW and SW need `addr[1:0]==0`.
- LH, LHU and SH need `addr[0]==0`.
- Byte ops, LWL and LWR are always aligned.
- A misaligned request is accepted, issues no bus strobe, and completes with `resp_err=1`.

Byte enables:
- All loads: 1111.
- SW: 1111.
- SH: 0011 when `addr[1]=0`, 1100 when `addr[1]=1`.
- SB: `4'b0001 << addr[1:0]`. Byte order is little-endian; lane 0 = byte address 0.

Write data:
- SW: `wdata`.
- SH: `{2{wdata[15:0]}}`.
- SB: `{4{wdata[7:0]}}`.

FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready=1`. On `req_valid`, latch op, address, `wdata` and mask codes, then:
  - misaligned → RESP with error set;
  - load → READ;
  - store → WRITE.
- READ: hold `avm_read=1` with stable address and byteenable. On the first cycle with `avm_waitrequest=0`, latch `avm_readdata` into `resp_data` and go to RESP.
- WRITE: hold `avm_write=1` with stable address, byteenable and writedata. On `avm_waitrequest=0`, go to RESP.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE. A new request cannot be accepted in RESP.

Response outputs:
- `resp_*` values stay stable from RESP until the next accept.
- `avm_read` and `avm_write` are never high together, and are never high outside READ/WRITE.

## Timing
- Accept in cycle 0 (`req_valid & req_ready`). Strobe is high from cycle 1.
- If `waitrequest` is low in cycle 1, `resp_valid` is high in cycle 2. Each extra `waitrequest` cycle adds 1. Minimum throughput is one access per 3 cycles.
- A misaligned access gives `resp_valid` in cycle 1, with no strobe.
- Read data arrives with zero read latency: it is sampled in the same cycle `waitrequest` drops.
- Reset values: state=IDLE, `req_ready=1` after reset deasserts, and all `avm_*` and `resp_*` outputs are 0.
- Reset mid-transaction: strobes drop at the next edge, the transaction is abandoned, and no `resp_valid` is produced.
- `req_valid` while not in IDLE is ignored; the requester must hold it until `req_ready`.

## Structure
- Package `mips_cpu_mem_pkg` holds:
  - the `mem_op_t` enum;
  - the `MSK_*` 3-bit mask-code constants shared with `wordmask`;
  - the `mem_state_t` enum;
  - an `is_misaligned(op, addr)` function.
- Sub-module `mips_cpu_store_align`: purely combinational; maps (op, `addr[1:0]`, `wdata`) to (byteenable, writedata). It is instantiated once.
- FSM and latches live in the top module.

## Test plan
- LW at 0x100, `waitrequest` low, readdata 0xDEADBEEF → `avm_address` 0x100 and byteenable 1111 in cycle 1; `resp_valid` in cycle 2 with data 0xDEADBEEF, `msk_cnt`=000, `msk_cnt2`=00.
- LB at 0x203 with `waitrequest` high for 3 cycles → address 0x200 held stable for 4 cycles; `resp_valid` 5 cycles after accept; `msk_cnt`=011, `msk_cnt2`=11.
- SB at 0x301, `wdata` 0x000000A5 → byteenable 0010, writedata 0xA5A5A5A5, `resp_data`=0.
- SH at 0x402, `wdata` 0x1234 → byteenable 1100, writedata 0x12341234.
- LW at 0x102 → no `avm_read`; `resp_valid` and `resp_err` high in cycle 1. LWR at 0x102 → normal read, `msk_cnt`=110, `msk_cnt2`=10.
- Assert `reset` while in READ with `waitrequest` high → `avm_read`=0 the next cycle, no `resp_valid`, `req_ready`=1 after reset.
